// File: rtl/bcd_gate_counter_if.sv
// Bundle between the gated BCD counter and the software-side PIOs.
// Latency: none, wires only.
// Backpressure: none; outputs are level-held results plus a done strobe.
interface bcd_gate_counter_if;
    logic       enable_i;
    logic [2:0] calibration_i;
    logic       sig_i;
    logic [3:0] unites_o;
    logic [3:0] dizaines_o;
    logic [3:0] centaines_o;
    logic [3:0] milliers_o;
    logic       overflow_o;
    logic       done_o;
    logic       busy_o;

    modport master (
        output enable_i, calibration_i, sig_i,
        input  unites_o, dizaines_o, centaines_o, milliers_o,
        input  overflow_o, done_o, busy_o
    );

    modport slave (
        input  enable_i, calibration_i, sig_i,
        output unites_o, dizaines_o, centaines_o, milliers_o,
        output overflow_o, done_o, busy_o
    );
endinterface

// File: rtl/bcd_gate_counter.sv
// Counts sig_i rising edges over a BASE_TICKS*10^k gate and latches four BCD digits.
// Latency: results land on the edge ending LATCH (gate end + 1); done_o pulses with them.
// Backpressure: none; each completed gate overwrites the previous result.
module bcd_gate_counter #(
    parameter int unsigned BASE_TICKS = 50000
) (
    input  logic clk_clk,
    input  logic reset_reset_n,
    bcd_gate_counter_if.slave bus
);
    localparam int PW = $clog2(BASE_TICKS);
    localparam logic [PW-1:0] PRE_TC = PW'(BASE_TICKS - 1);

    typedef enum logic [1:0] {IDLE, GATE, LATCH} state_t;

    state_t      state_q, state_d;
    logic        gate_start;
    logic        gate_end;
    logic        sync1_q, sync2_q, hist_q;
    logic        sig_edge;
    logic [2:0]  calib_q;
    logic [PW-1:0] pre_q;
    logic [13:0] unit_q;
    logic [13:0] unit_tc;
    logic [15:0] cnt_q;
    logic        ovf_q;
    logic [15:0] res_q;
    logic        res_ovf_q;
    logic        done_q;

    // Digit-wise decimal increment; carry ripples through all four digits in one cycle.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= bus.sig_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign sig_edge = sync2_q & ~hist_q;

    // Codes above 4 clamp to the longest gate.
    always_comb begin
        unit_tc = 14'd9999;
        case (calib_q)
            3'd0:    unit_tc = 14'd0;
            3'd1:    unit_tc = 14'd9;
            3'd2:    unit_tc = 14'd99;
            3'd3:    unit_tc = 14'd999;
            default: unit_tc = 14'd9999;
        endcase
    end

    assign gate_end = (state_q == GATE) && (pre_q == PRE_TC) && (unit_q == unit_tc);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gate_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.enable_i) begin
                    state_d    = GATE;
                    gate_start = 1'b1;
                end
            end
            GATE: begin
                // Dropping enable abandons the gate without publishing anything.
                if (!bus.enable_i) begin
                    state_d = IDLE;
                end else if (gate_end) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                if (bus.enable_i) begin
                    state_d    = GATE;
                    gate_start = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            calib_q <= 3'd0;
        end else if (gate_start) begin
            calib_q <= bus.calibration_i;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pre_q  <= '0;
            unit_q <= '0;
        end else if (state_q != GATE || gate_end) begin
            pre_q  <= '0;
            unit_q <= '0;
        end else if (pre_q == PRE_TC) begin
            pre_q  <= '0;
            unit_q <= unit_q + 14'd1;
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

    // Edges outside GATE (including the LATCH dead cycle) are dropped.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cnt_q <= 16'h0000;
            ovf_q <= 1'b0;
        end else if (state_q != GATE) begin
            cnt_q <= 16'h0000;
            ovf_q <= 1'b0;
        end else if (sig_edge) begin
            if (cnt_q == 16'h9999) begin
                ovf_q <= 1'b1;
            end else begin
                cnt_q <= bcd_inc(cnt_q);
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            res_q     <= 16'h0000;
            res_ovf_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state_q == LATCH);
            if (state_q == LATCH) begin
                res_q     <= cnt_q;
                res_ovf_q <= ovf_q;
            end
        end
    end

    assign bus.unites_o    = res_q[3:0];
    assign bus.dizaines_o  = res_q[7:4];
    assign bus.centaines_o = res_q[11:8];
    assign bus.milliers_o  = res_q[15:12];
    assign bus.overflow_o  = res_ovf_q;
    assign bus.done_o      = done_q;
    assign bus.busy_o      = (state_q != IDLE);
endmodule

// File: doc/bcd_gate_counter.md
# bcd_gate_counter

Hardware gated event counter that feeds the four BCD digit inputs (units, tens, hundreds, thousands) read by the Nios II software through its PIOs. The software's 3-bit calibration output selects the gate duration. The block counts rising edges of an external signal over that gate, then latches the result as four BCD digits, with an overflow flag and a one-cycle completion strobe. It runs gates back-to-back while enabled, so software always reads the most recent completed measurement.

## Interface
Parameters:
- BASE_TICKS, 50000, clock cycles per base gate unit (1 ms at 50 MHz); must be ≥ 2.

Ports:
- clk_clk  in  1  system clock; all logic on the rising edge.
- reset_reset_n  in  1  asynchronous, active-low reset.
- enable_i  in  1  run continuous measurement while high.
- calibration_i  in  3  gate select; sampled at each gate start.
- sig_i  in  1  asynchronous signal under measurement.
- unites_o  out  4  latched BCD units digit.
- dizaines_o  out  4  latched BCD tens digit.
- centaines_o  out  4  latched BCD hundreds digit.
- milliers_o  out  4  latched BCD thousands digit.
- overflow_o  out  1  latched: last gate saw more than 9999 edges.
- done_o  out  1  one-cycle pulse when the digit outputs update.
- busy_o  out  1  high in GATE and LATCH.

## Operation
- **Synchronizer:** sig_i passes through 2 flops plus one history flop. An edge is `s2 & ~s3`.
- **Gate length:** N = BASE_TICKS × 10^k cycles, where k = calib_q for codes 0–4. Codes 5–7 clamp to k = 4.
- **Gate timer:** a prescaler counts 0..BASE_TICKS-1. A unit counter counts prescaler wraps, 0..10^k-1 (14 bits). The gate ends when both are at terminal count.
- **Internal BCD counter:** 4 digits, ripple decimal carry within the same cycle.
  - 9999 + edge → saturates at 9999 and sets an internal overflow bit.
- **State machine:**
  - IDLE: timers and internal count held at 0. If enable_i = 1, go to GATE. On that transition, load calib_q and clear the count and overflow bit.
  - GATE: count edges and advance the timer. The Nth GATE cycle is the last; its edge is counted. Then go to LATCH. If enable_i = 0 in any GATE cycle, go to IDLE next cycle: the gate is aborted, outputs are unchanged, and no done_o.
  - LATCH (1 cycle): copy the internal count and overflow bit to the outputs (registered), then clear the internal count.
    - An edge detected during LATCH is discarded (1-cycle dead time).
    - Next state is GATE if enable_i = 1, reloading calib_q. Otherwise IDLE.
- **Calibration changes:** a change during GATE or IDLE has no effect until the next GATE entry.
- **Reset:** asserting reset at any time forces IDLE immediately. All outputs and internal registers go to 0.

## Timing
- **Reset values:** all digit outputs 0, overflow_o 0, done_o 0, busy_o 0.
- **sig_i to count:** a sig_i rising edge is counted 3 cycles after it is sampled.
- **Measurement period:** continuous mode runs N + 1 cycles per measurement (N GATE cycles + 1 LATCH cycle).
- **Output update:** digits and overflow_o update on the clock edge ending LATCH. done_o is high for exactly the following cycle, coincident with the new values.
- **busy_o:** rises the cycle after enable_i is seen high in IDLE. It stays high continuously across back-to-back gates.
- **Outputs between updates:** stable between done_o pulses, and held indefinitely in IDLE.

## Test plan
Use BASE_TICKS = 10 for all scenarios.
1. **Reset:** assert reset_reset_n = 0 mid-gate with sig_i toggling → all outputs 0 within the same cycle. After release with enable_i = 0: busy_o = 0 and no done_o.
2. **Basic count:** calibration_i = 2 (1000-cycle gate), 37 clean pulses (4 cycles high, 4 low) inside the window → done_o once; milliers..unites = 0,0,3,7; overflow_o = 0. Successive done_o pulses are 1001 cycles apart.
3. **Overflow:** calibration_i = 4 (100000 cycles), sig_i period 4 → digits 9,9,9,9 and overflow_o = 1. The next gate with sig_i idle → 0,0,0,0 and overflow_o = 0.
4. **Clamp:** calibration_i = 6 → done_o spacing 100001 cycles, identical to code 4.
5. **Mid-gate calibration change:** change calibration_i from 0 to 1 mid-gate → the current gate still ends after 10 cycles; the next gate lasts 100 cycles.
6. **Abort:** enable_i dropped at cycle 500 of a 1000-cycle gate with a previous result 0,1,2,3 → IDLE next cycle, busy_o = 0, no done_o, outputs still 0,1,2,3.
